// File: rtl/hack_pkg.sv
// Shared definitions for the Hack gate library: word width and the word type
// reused by every 16-bit gate.
package hack_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

endpackage : hack_pkg

// File: rtl/or_16_or1.sv
// One-bit OR built only from NANDs, matching the rest of the NAND-based gate
// library: or(a,b) = nand(nand(a,a), nand(b,b)).
module or1 (
   input  logic a,
   input  logic b,
   output logic y
);

   logic notA;
   logic notB;

   assign notA = ~(a & a);
   assign notB = ~(b & b);
   assign y    = ~(notA & notB);

endmodule : or1

// File: rtl/or_16.sv
// Word-wide OR for the Hack datapath: a purely combinational result plus a
// registered copy and any/all status flags for pipelined consumers.
module or_16
   import hack_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             any_q,
   output logic             all_q
);

   logic [WIDTH-1:0] y_d;
   logic             any_d;
   logic             all_d;

   // Each result bit is an independent gate; nothing crosses bit positions.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      or1 u_or1 (
         .a (a[i]),
         .b (b[i]),
         .y (y[i])
      );
   end

   always_comb begin
      y_d   = y;
      any_d = |y;
      all_d = &y;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q   <= '0;
         any_q <= 1'b0;
         all_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         any_q <= any_d;
         all_q <= all_d;
      end
   end

endmodule : or_16

// File: tb/tb_or_16.sv
// Self-checking bench for or_16: combinational result checked immediately,
// registered outputs checked one edge later against a queued expectation.
module tb_or_16;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] y;
   logic [15:0] y_q;
   logic        any_q;
   logic        all_q;

   logic clkRun;
   int   total;
   int   bad;

   typedef struct {
      logic [15:0] yExp;
      logic        anyExp;
      logic        allExp;
   } regExp_t;

   regExp_t scoreboard[$];

   or_16 #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .y     (y),
      .y_q   (y_q),
      .any_q (any_q),
      .all_q (all_q)
   );

   // Clock stays parked low until the no-clock combinational check is done.
   always begin
      #5;
      if (clkRun) clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
      end
   endtask

   // Drive one vector, check y now, queue the register expectation, and
   // compare it against the outputs after the following rising edge.
   task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn,
                                input logic rstIn);
      regExp_t expIn;
      regExp_t expOut;
      logic [15:0] orVal;
      @(negedge clk);
      a   = aIn;
      b   = bIn;
      rst = rstIn;
      #1;
      orVal = aIn | bIn;
      checkOutput("y", y, orVal);
      expIn.yExp   = rstIn ? 16'h0000 : orVal;
      expIn.anyExp = rstIn ? 1'b0 : (orVal != 16'h0000);
      expIn.allExp = rstIn ? 1'b0 : (orVal == 16'hFFFF);
      scoreboard.push_back(expIn);
      @(posedge clk);
      #1;
      expOut = scoreboard.pop_front();
      checkOutput("y_q", y_q, expOut.yExp);
      checkOutput("any_q", {15'd0, any_q}, {15'd0, expOut.anyExp});
      checkOutput("all_q", {15'd0, all_q}, {15'd0, expOut.allExp});
      checkOutput("yHold", y, orVal);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      total  = 0;
      bad    = 0;
      clk    = 1'b0;
      clkRun = 1'b0;
      rst    = 1'b0;

      a = 16'h0000;
      b = 16'hFFFF;
      #50;
      checkOutput("yNoClock", y, 16'hFFFF);
      rst = 1'b1;
      #10;
      checkOutput("yInReset", y, 16'hFFFF);

      clkRun = 1'b1;
      applyStimulus(16'h1234, 16'h4321, 1'b1);

      applyStimulus(16'hAAAA, 16'h5555, 1'b0);
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
      applyStimulus(16'h0001, 16'h8000, 1'b0);

      applyStimulus(16'h00F0, 16'h0F00, 1'b0);
      applyStimulus(16'h00F0, 16'h0F00, 1'b1);
      applyStimulus(16'h00F0, 16'h0F00, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         applyStimulus(ra, rb, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_or_16
